// File: rtl/risc_cpu_subsystem.sv
// Purpose: 8-bit accumulator CPU core with a 13-bit bus, address decoder and internal 1K x 8 data RAM.
// Latency: every instruction takes 8 clocks (s0..s7); HLT parks the core in s3 until reset.
// Backpressure: none; the external ROM must return rom_data for addr within the same cycle.
// Ports: clk, reset (synchronous, active-high); rom_data from the program ROM;
//        addr/rd/wr/rom_sel/ram_sel/data describe the bus each cycle;
//        halt/opcode/ir_addr/pc_addr/fetch expose the core state for observation.
module risc_cpu_subsystem #(
    parameter int          RAM_DEPTH = 1024,
    parameter logic [12:0] PC_RESET  = 13'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rom_data,
    output logic [12:0] addr,
    output logic        rd,
    output logic        wr,
    output logic        rom_sel,
    output logic        ram_sel,
    output logic [7:0]  data,
    output logic        halt,
    output logic [2:0]  opcode,
    output logic [12:0] ir_addr,
    output logic [12:0] pc_addr,
    output logic        fetch
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_t;

    state_t      s;
    logic [12:0] pc;
    logic [15:0] ir;
    logic [7:0]  acc;
    logic [7:0]  mem [RAM_DEPTH];

    logic        operand_op;
    logic        sto_drive;

    assign opcode  = ir[15:13];
    assign ir_addr = ir[12:0];
    assign pc_addr = pc;
    assign fetch   = ~s[2];
    assign addr    = fetch ? pc : ir[12:0];

    // Opcodes that read their operand in s4/s5.
    assign operand_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                        (opcode == OP_XOR) || (opcode == OP_LDA);

    assign rd = (s == S0) || (s == S1) ||
                (((s == S4) || (s == S5)) && operand_op);
    assign wr = (s == S5) && (opcode == OP_STO);
    assign sto_drive = (opcode == OP_STO) && ((s == S4) || (s == S5) || (s == S6));

    // Top 2K of the space is RAM (the 1K array appears twice); everything else is ROM.
    assign ram_sel = (addr[12:11] == 2'b11);
    assign rom_sel = ~ram_sel;

    // The core never leaves s3 while an HLT is in the IR, so this term alone
    // holds halt high (and freezes every other output) until reset.
    assign halt = (s == S3) && (opcode == OP_HLT);

    always_comb begin
        data = 8'h00;
        if (rd && ram_sel) begin
            data = mem[addr[RAM_AW-1:0]];
        end else if (rd && rom_sel) begin
            data = rom_data;
        end else if (sto_drive) begin
            data = acc;
        end
    end

    // RAM is not cleared by reset; a store aborted by reset must not land.
    always_ff @(posedge clk) begin
        if (!reset && wr && ram_sel) begin
            mem[addr[RAM_AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s   <= S0;
            pc  <= PC_RESET;
            ir  <= 16'h0000;
            acc <= 8'h00;
        end else if (!halt) begin
            s <= state_t'(s + 3'd1);
            case (s)
                S0: begin
                    ir[15:8] <= data;
                    pc       <= pc + 13'd1;
                end
                S1: begin
                    ir[7:0] <= data;
                    pc      <= pc + 13'd1;
                end
                S4: begin
                    if (opcode == OP_JMP) begin
                        pc <= ir[12:0];
                    end
                end
                S5: begin
                    case (opcode)
                        OP_ADD:  acc <= acc + data;
                        OP_AND:  acc <= acc & data;
                        OP_XOR:  acc <= acc ^ data;
                        OP_LDA:  acc <= data;
                        OP_SKZ: begin
                            if (acc == 8'h00) begin
                                pc <= pc + 13'd2;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_cpu_subsystem.sv
module tb_risc_cpu_subsystem;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rom_data;
    logic [12:0] addr;
    logic        rd;
    logic        wr;
    logic        rom_sel;
    logic        ram_sel;
    logic [7:0]  data;
    logic        halt;
    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic [12:0] pc_addr;
    logic        fetch;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    logic [7:0] rom [0:8191];
    assign rom_data = rom[addr];

    always #5 clk = ~clk;

    risc_cpu_subsystem dut (
        .clk      (clk),
        .reset    (reset),
        .rom_data (rom_data),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .rom_sel  (rom_sel),
        .ram_sel  (ram_sel),
        .data     (data),
        .halt     (halt),
        .opcode   (opcode),
        .ir_addr  (ir_addr),
        .pc_addr  (pc_addr),
        .fetch    (fetch)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [12:0] fetch_q [$];   // pc of each instruction fetch (s0)
    logic [22:0] store_q [$];   // {addr, ram_sel, rom_sel, data} on each wr
    int          halt_q  [$];   // cycle (from reset release) where halt rises
    logic [12:0] addr_q  [$];   // per-cycle addr trace right after release

    int   cyc        = 0;
    logic prev_fetch = 1'b0;
    logic prev_halt  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_fetch(input logic [12:0] a);
        fetch_q.push_back(a);
    endtask

    task automatic exp_store(input logic [12:0] a, input logic r, input logic [7:0] d);
        store_q.push_back({a, r, ~r, d});
    endtask

    task automatic put(input int pc, input logic [2:0] op, input logic [12:0] a);
        rom[pc]     = {op, a[12:8]};
        rom[pc + 1] = a[7:0];
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
    endtask

    // Called just after a rising edge; two reset edges, then checks and release.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc_addr", 32'(pc_addr), 32'h0);
        chk("rst_fetch",   32'(fetch),   32'h1);
        chk("rst_halt",    32'(halt),    32'h0);
        reset = 1'b0;
    endtask

    // Run to halt (bounded), stay parked a while, then check the frozen state.
    task automatic run_to_halt(input int limit, input logic [12:0] final_pc);
        for (int i = 0; i < limit && halt !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("halt_held",   32'(halt),    32'h1);
        chk("halt_pc",     32'(pc_addr), 32'(final_pc));
    endtask

    task automatic end_phase(input string name);
        chk({name, "_fetch_left"}, 32'(fetch_q.size()), 32'h0);
        chk({name, "_store_left"}, 32'(store_q.size()), 32'h0);
        chk({name, "_halt_left"},  32'(halt_q.size()),  32'h0);
        chk({name, "_addr_left"},  32'(addr_q.size()),  32'h0);
        fetch_q.delete();
        store_q.delete();
        halt_q.delete();
        addr_q.delete();
    endtask

    // Monitor: samples on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (reset) begin
            cyc        = 0;
            prev_fetch = 1'b0;
            prev_halt  = 1'b0;
        end else begin
            if (addr_q.size() > 0) begin
                chk("addr_trace", 32'(addr), 32'(addr_q.pop_front()));
            end
            chk("rd_wr_exclusive", 32'(rd & wr), 32'h0);
            if (fetch && rd && !prev_fetch) begin
                if (fetch_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got pc 0x%0h, expected none (cycle %0d)", pc_addr, cyc);
                end else begin
                    logic [12:0] e;
                    e = fetch_q.pop_front();
                    chk("fetch", 32'({pc_addr, addr, rom_sel}), 32'({e, e, 1'b1}));
                end
            end
            if (wr) begin
                if (store_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_store: got addr 0x%0h data 0x%0h, expected none (cycle %0d)", addr, data, cyc);
                end else begin
                    chk("store", 32'({addr, ram_sel, rom_sel, data}), 32'(store_q.pop_front()));
                end
            end
            if (halt && !prev_halt) begin
                if (halt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_halt: got halt at cycle %0d, expected none", cyc);
                end else begin
                    chk("halt_cycle", 32'(cyc), 32'(halt_q.pop_front()));
                end
            end
            prev_fetch = fetch;
            prev_halt  = halt;
            cyc++;
        end
    end

    initial begin
        logic [7:0] fa, fb, fc;

        for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
        // Constant pool in ROM, used to seed RAM and as ROM-space operands.
        rom[13'h100] = 8'h05; rom[13'h101] = 8'h07;
        rom[13'h102] = 8'hF0; rom[13'h103] = 8'h3C;
        rom[13'h104] = 8'hFF; rom[13'h105] = 8'h02;
        rom[13'h106] = 8'h00; rom[13'h107] = 8'h01;

        // Seed RAM[0]=05, RAM[1]=07 for the next program (survives reset).
        clr_prog();
        put(0, LDA, 13'h0100); put(2, STO, 13'h1800);
        put(4, LDA, 13'h0101); put(6, STO, 13'h1801);
        put(8, HLT, 13'h0000);
        for (int i = 0; i < 5; i++) exp_fetch(13'(2 * i));
        exp_store(13'h1800, 1'b1, 8'h05);
        exp_store(13'h1801, 1'b1, 8'h07);
        halt_q.push_back(4 * 8 + 3);
        do_reset();
        run_to_halt(100, 13'h000A);
        end_phase("seed");

        // Load/add/store: 5 + 7 = 0C; HLT is the 4th instruction -> halt in cycle 27.
        // PC has already stepped past the HLT word (6,7) when it freezes.
        @(posedge clk); #1;
        clr_prog();
        put(0, LDA, 13'h1800); put(2, ADD, 13'h1801);
        put(4, STO, 13'h1802); put(6, HLT, 13'h0000);
        addr_q = '{13'h0000, 13'h0001, 13'h0002, 13'h0002,
                   13'h1800, 13'h1800, 13'h1800, 13'h1800};
        for (int i = 0; i < 4; i++) exp_fetch(13'(2 * i));
        exp_store(13'h1802, 1'b1, 8'h0C);
        halt_q.push_back(27);
        do_reset();
        run_to_halt(100, 13'h0008);
        end_phase("ldaddsto");

        // Logic and wrap: F0&3C=30, 30^3C=0C, FF+02=01.
        @(posedge clk); #1;
        clr_prog();
        put(0,  LDA, 13'h0102); put(2,  STO, 13'h1800);
        put(4,  LDA, 13'h0103); put(6,  STO, 13'h1801);
        put(8,  LDA, 13'h1800); put(10, AND, 13'h1801);
        put(12, STO, 13'h1802); put(14, XOR, 13'h1801);
        put(16, STO, 13'h1803); put(18, LDA, 13'h0104);
        put(20, ADD, 13'h0105); put(22, STO, 13'h1804);
        put(24, HLT, 13'h0000);
        for (int i = 0; i < 13; i++) exp_fetch(13'(2 * i));
        exp_store(13'h1800, 1'b1, 8'hF0);
        exp_store(13'h1801, 1'b1, 8'h3C);
        exp_store(13'h1802, 1'b1, 8'h30);
        exp_store(13'h1803, 1'b1, 8'h0C);
        exp_store(13'h1804, 1'b1, 8'h01);
        halt_q.push_back(12 * 8 + 3);
        do_reset();
        run_to_halt(200, 13'h001A);
        end_phase("logic");

        // SKZ taken (acc=0) then not taken (acc=1), JMP into 0x0010,
        // STO into ROM space 0x0005 must not touch RAM[5] (still 00).
        @(posedge clk); #1;
        clr_prog();
        put(0,  LDA, 13'h0106); put(2,  STO, 13'h1805);
        put(4,  SKZ, 13'h0000); put(6,  JMP, 13'h0010);
        put(8,  LDA, 13'h0107); put(10, JMP, 13'h0004);
        put(16, STO, 13'h0005); put(18, LDA, 13'h1805);
        put(20, STO, 13'h1806); put(22, HLT, 13'h0000);
        fetch_q = '{13'h0000, 13'h0002, 13'h0004, 13'h0008, 13'h000A,
                    13'h0004, 13'h0006, 13'h0010, 13'h0012, 13'h0014, 13'h0016};
        exp_store(13'h1805, 1'b1, 8'h00);
        exp_store(13'h0005, 1'b0, 8'h01);
        exp_store(13'h1806, 1'b1, 8'h00);
        halt_q.push_back(10 * 8 + 3);
        do_reset();
        run_to_halt(200, 13'h0018);
        end_phase("skz_jmp");

        // Fibonacci in RAM[2]: 1, 2, 3, 5, 8, 0D; reset lands in s5 of the 7th ADD.
        @(posedge clk); #1;
        clr_prog();
        put(0,  STO, 13'h1800); put(2,  LDA, 13'h0107);
        put(4,  STO, 13'h1801); put(6,  LDA, 13'h1800);
        put(8,  ADD, 13'h1801); put(10, STO, 13'h1802);
        put(12, LDA, 13'h1801); put(14, STO, 13'h1800);
        put(16, LDA, 13'h1802); put(18, STO, 13'h1801);
        put(20, JMP, 13'h0006);
        exp_fetch(13'h0000); exp_fetch(13'h0002); exp_fetch(13'h0004);
        exp_store(13'h1800, 1'b1, 8'h00);
        exp_store(13'h1801, 1'b1, 8'h01);
        fa = 8'h00;
        fb = 8'h01;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < 8; k++) exp_fetch(13'(6 + 2 * k));
            fc = fa + fb;
            exp_store(13'h1802, 1'b1, fc);
            exp_store(13'h1800, 1'b1, fb);
            exp_store(13'h1801, 1'b1, fc);
            fa = fb;
            fb = fc;
        end
        exp_fetch(13'h0006); exp_fetch(13'h0008);
        do_reset();
        // Instruction 52 is the 7th loop ADD; its s5 is cycle 52*8+5.
        repeat (421) @(posedge clk);
        #1;
        chk("abort_in_add_op", 32'(opcode), 32'(ADD));
        chk("abort_in_s5_rd",  32'({rd, fetch}), 32'h2);
        end_phase("fib");

        // After the abort: acc must read 00, RAM[2]=0D and RAM[0]=08 must survive.
        clr_prog();
        put(0, STO, 13'h1803); put(2, LDA, 13'h1802);
        put(4, STO, 13'h1804); put(6, LDA, 13'h1800);
        put(8, STO, 13'h1805); put(10, HLT, 13'h0000);
        for (int i = 0; i < 6; i++) exp_fetch(13'(2 * i));
        exp_store(13'h1803, 1'b1, 8'h00);
        exp_store(13'h1804, 1'b1, 8'h0D);
        exp_store(13'h1805, 1'b1, 8'h08);
        halt_q.push_back(5 * 8 + 3);
        do_reset();
        run_to_halt(100, 13'h000C);
        end_phase("post_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
